// File: rtl/peripheral_wb_burst_master.sv
// peripheral_wb_burst_master
//   Wishbone B3 master engine for the GPIO subsystem DMA / test sequencer.
//   Executes one command at a time as a classic cycle, a constant-address
//   burst or an incrementing burst (linear, wrap4, wrap8, wrap16). Write data
//   arrives on a valid/ready stream, read data leaves as a one-cycle strobe.
//   After each command a programmable idle gap is inserted, then done_o
//   (with err_o on abort) pulses for one cycle.
//
// Ports
//   wb_clk_i, wb_rst_ni            clock, async active-low reset
//   cmd_valid_i / cmd_ready_o      command handshake
//   cmd_we_i, cmd_adr_i, cmd_sel_i command direction, start byte address, byte select
//   cmd_cti_i, cmd_bte_i           000 classic, 001 constant, 010 incrementing; burst type
//   cmd_len_i, cmd_wait_i          beat count, idle cycles after the command
//   wdat_valid_i/wdat_i/wdat_ready_o  write data stream
//   rdat_valid_o/rdat_o            read data strobe (no backpressure)
//   done_o, err_o                  completion pulse, abort flag
//   wb_*_o / wb_*_i                Wishbone master interface
//
// Configuration
//   PERIPHERAL_WB_MASTER_RETRY_EN  defined: wb_rty_i re-issues the beat up to
//                                  MAX_RETRY times; undefined: rty acts as err.
//
// state | meaning
// IDLE  | ready for a command
// LOAD  | waiting for a write word (cyc kept high inside a burst)
// REQ   | strobe asserted, waiting for ack/err/rty
// GAP   | idle gap count-down, done_o on the last cycle

module peripheral_wb_burst_master #(
    parameter int AW              = 32,
    parameter int DW              = 32,
    parameter int MAX_BURST_LEN   = 16,
    parameter int MAX_WAIT_STATES = 8,
    parameter int MAX_RETRY       = 4
) (
    input  logic                             wb_clk_i,
    input  logic                             wb_rst_ni,
    input  logic                             cmd_valid_i,
    output logic                             cmd_ready_o,
    input  logic                             cmd_we_i,
    input  logic [AW-1:0]                    cmd_adr_i,
    input  logic [DW/8-1:0]                  cmd_sel_i,
    input  logic [2:0]                       cmd_cti_i,
    input  logic [1:0]                       cmd_bte_i,
    input  logic [$clog2(MAX_BURST_LEN):0]   cmd_len_i,
    input  logic [$clog2(MAX_WAIT_STATES):0] cmd_wait_i,
    input  logic                             wdat_valid_i,
    input  logic [DW-1:0]                    wdat_i,
    output logic                             wdat_ready_o,
    output logic                             rdat_valid_o,
    output logic [DW-1:0]                    rdat_o,
    output logic                             done_o,
    output logic                             err_o,
    output logic [AW-1:0]                    wb_adr_o,
    output logic [DW-1:0]                    wb_dat_o,
    output logic [DW/8-1:0]                  wb_sel_o,
    output logic                             wb_we_o,
    output logic                             wb_cyc_o,
    output logic                             wb_stb_o,
    output logic [2:0]                       wb_cti_o,
    output logic [1:0]                       wb_bte_o,
    input  logic [DW-1:0]                    wb_dat_i,
    input  logic                             wb_ack_i,
    input  logic                             wb_err_i,
    input  logic                             wb_rty_i
);

    localparam int ADR_LSB = $clog2(DW/8);
    localparam int LW      = $clog2(MAX_BURST_LEN) + 1;
    localparam int WW      = $clog2(MAX_WAIT_STATES) + 1;
    localparam int RW      = ($clog2(MAX_RETRY + 1) < 1) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [LW-1:0] LEN_MAX   = LW'(MAX_BURST_LEN);
    localparam logic [WW-1:0] WAIT_MAX  = WW'(MAX_WAIT_STATES);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

`ifdef PERIPHERAL_WB_MASTER_RETRY_EN
    localparam logic RETRY_EN = 1'b1;
`else
    localparam logic RETRY_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, LOAD, REQ, GAP} state_t;

    state_t          state_q, state_d;
    logic            alive_q;
    logic            we_q;
    logic [AW-1:0]   adr_q, adr_next;
    logic [DW/8-1:0] sel_q;
    logic [2:0]      cti_q;
    logic [1:0]      bte_q;
    logic [LW-1:0]   left_q, len_eff;
    logic [WW-1:0]   wait_q, wait_eff;
    logic [DW-1:0]   dat_q;
    logic            in_burst_q;
    logic            err_q;
    logic            hold_q;
    logic [RW-1:0]   retry_q;
    logic [DW-1:0]   rdat_q;
    logic            rvalid_q;

    logic accept, wpop, ack_beat, abort, retry;
    logic is_burst_cmd, last;

    assign last         = (left_q == LW'(1));
    assign is_burst_cmd = (cmd_cti_i == CTI_CONST) || (cmd_cti_i == CTI_INCR);

    // Unknown cti codes are executed as classic single cycles.
    always_comb begin
        len_eff = cmd_len_i;
        if (!is_burst_cmd || cmd_len_i == '0)
            len_eff = LW'(1);
        else if (cmd_len_i > LEN_MAX)
            len_eff = LEN_MAX;
        wait_eff = (cmd_wait_i > WAIT_MAX) ? WAIT_MAX : cmd_wait_i;
    end

    // Wrap bursts only roll the beat-index bits; upper address bits stay put.
    always_comb begin
        adr_next = adr_q;
        if (cti_q == CTI_INCR) begin
            case (bte_q)
                2'b01:   adr_next[ADR_LSB +: 2] = adr_q[ADR_LSB +: 2] + 2'd1;
                2'b10:   adr_next[ADR_LSB +: 3] = adr_q[ADR_LSB +: 3] + 3'd1;
                2'b11:   adr_next[ADR_LSB +: 4] = adr_q[ADR_LSB +: 4] + 4'd1;
                default: adr_next = adr_q + AW'(DW/8);
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        wpop     = 1'b0;
        ack_beat = 1'b0;
        abort    = 1'b0;
        retry    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid_i && alive_q) begin
                    accept  = 1'b1;
                    state_d = cmd_we_i ? LOAD : REQ;
                end
            end
            LOAD: begin
                if (wdat_valid_i) begin
                    wpop    = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                // During a retry hold the strobe is low, so bus responses are ignored.
                if (!hold_q) begin
                    if (wb_ack_i) begin
                        ack_beat = 1'b1;
                        if (last)
                            state_d = GAP;
                        else if (we_q)
                            state_d = LOAD;
                    end else if (wb_err_i) begin
                        abort   = 1'b1;
                        state_d = GAP;
                    end else if (wb_rty_i) begin
                        if (RETRY_EN && retry_q != RETRY_MAX) begin
                            retry = 1'b1;
                        end else begin
                            abort   = 1'b1;
                            state_d = GAP;
                        end
                    end
                end
            end
            GAP: begin
                if (wait_q == '0)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            alive_q    <= 1'b0;
            we_q       <= 1'b0;
            adr_q      <= '0;
            sel_q      <= '0;
            cti_q      <= '0;
            bte_q      <= '0;
            left_q     <= '0;
            wait_q     <= '0;
            dat_q      <= '0;
            in_burst_q <= 1'b0;
            err_q      <= 1'b0;
            hold_q     <= 1'b0;
            retry_q    <= '0;
            rdat_q     <= '0;
            rvalid_q   <= 1'b0;
        end else begin
            alive_q  <= 1'b1;
            hold_q   <= retry;
            rvalid_q <= ack_beat && !we_q;
            if (accept) begin
                we_q       <= cmd_we_i;
                adr_q      <= cmd_adr_i;
                sel_q      <= cmd_sel_i;
                cti_q      <= is_burst_cmd ? cmd_cti_i : CTI_CLASSIC;
                bte_q      <= cmd_bte_i;
                left_q     <= len_eff;
                wait_q     <= wait_eff;
                in_burst_q <= 1'b0;
                err_q      <= 1'b0;
                retry_q    <= '0;
            end
            if (wpop)
                dat_q <= wdat_i;
            if (retry)
                retry_q <= retry_q + 1'b1;
            if (ack_beat) begin
                retry_q    <= '0;
                left_q     <= left_q - 1'b1;
                adr_q      <= adr_next;
                in_burst_q <= 1'b1;
                if (!we_q)
                    rdat_q <= wb_dat_i;
            end
            if (abort)
                err_q <= 1'b1;
            if (state_q == GAP && wait_q != '0)
                wait_q <= wait_q - 1'b1;
        end
    end

    // alive_q keeps cmd_ready_o low while reset is asserted even though IDLE is the reset state.
    assign cmd_ready_o  = (state_q == IDLE) && alive_q;
    assign wdat_ready_o = (state_q == LOAD);
    assign rdat_valid_o = rvalid_q;
    assign rdat_o       = rdat_q;
    assign done_o       = (state_q == GAP) && (wait_q == '0);
    assign err_o        = done_o && err_q;

    assign wb_cyc_o = (state_q == REQ) || (state_q == LOAD && in_burst_q);
    assign wb_stb_o = (state_q == REQ) && !hold_q;
    assign wb_adr_o = adr_q;
    assign wb_dat_o = dat_q;
    assign wb_sel_o = wb_cyc_o ? sel_q : '0;
    assign wb_we_o  = wb_cyc_o && we_q;
    assign wb_cti_o = !wb_cyc_o ? CTI_CLASSIC :
                      (cti_q != CTI_CLASSIC && last) ? CTI_END : cti_q;
    assign wb_bte_o = (wb_cyc_o && cti_q == CTI_INCR) ? bte_q : 2'b00;

endmodule
